uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter core among N_REQ byte requesters using round-robin arbitration.
- Each requester presents bytes on a valid/ready handshake.
- The arbiter issues one byte at a time to the core: a one-cycle data-valid pulse plus the byte. It then follows the core's active/done outputs before granting the next byte.
- Sits between peripheral/CPU-side byte producers (debug console, bootloader echo, printf path) and the serializer.

---
 rtl/uart_tx_arbiter.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX core among N_REQ byte requesters.
// Optional sticky per-line grant when UART_ARB_LOCK_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transfer; arbitrate among valid requesters
// ISSUE     | one cycle: tx_dv and req_ready to the granted requester
// WAIT_ACT  | waiting for tx_active; times out after ACT_TIMEOUT cycles
// WAIT_DONE | core is serializing; waiting for tx_done
// GAP       | one cycle covering the core's cleanup cycle
module uart_tx_arbiter #(
   parameter int  N_REQ       = 4,
   parameter int  ACT_TIMEOUT = 4,
   localparam int ID_W        = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 tx_dv,
   output logic [7:0]           tx_byte,
   input  logic                 tx_active,
   input  logic                 tx_done,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 err
);

   localparam int              CNT_W    = (ACT_TIMEOUT > 2) ? $clog2(ACT_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACT_TIMEOUT - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACT,
      WAIT_DONE,
      GAP
   } state_t;

   state_t           state, state_nxt;
   logic [ID_W-1:0]  grant_nxt;
   logic [ID_W-1:0]  winner;
   logic             any_valid;
   logic [7:0]       byte_nxt;
   logic [CNT_W-1:0] act_cnt, cnt_nxt;
   logic             err_nxt;

`ifdef UART_ARB_LOCK_EN
   // Set when the transfer just abandoned on timeout, so GAP does not re-lock.
   logic lock_brk, lock_brk_nxt;
`endif

   function automatic logic [7:0] byte_sel(input logic [8*N_REQ-1:0] data,
                                           input logic [ID_W-1:0]    idx);
      return data[8*int'(idx) +: 8];
   endfunction

   // Search starts just after the last grant so the last winner is lowest priority.
   always_comb begin
      any_valid = 1'b0;
      winner    = grant_id;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!any_valid && req_valid[(int'(grant_id) + k) % N_REQ]) begin
            any_valid = 1'b1;
            winner    = ID_W'((int'(grant_id) + k) % N_REQ);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      byte_nxt  = tx_byte;
      cnt_nxt   = act_cnt;
      err_nxt   = err;
`ifdef UART_ARB_LOCK_EN
      lock_brk_nxt = lock_brk;
`endif
      case (state)
         IDLE: begin
            if (any_valid) begin
               grant_nxt = winner;
               byte_nxt  = byte_sel(req_data, winner);
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = WAIT_ACT;
`ifdef UART_ARB_LOCK_EN
            lock_brk_nxt = 1'b0;
`endif
         end
         WAIT_ACT: begin
            // A done pulse with a missed active edge still counts as completion.
            if (tx_done) begin
               state_nxt = GAP;
            end else if (tx_active) begin
               state_nxt = WAIT_DONE;
            end else if (act_cnt == CNT_LAST) begin
               err_nxt   = 1'b1;
               state_nxt = GAP;
`ifdef UART_ARB_LOCK_EN
               lock_brk_nxt = 1'b1;
`endif
            end else begin
               cnt_nxt = act_cnt + CNT_W'(1);
            end
         end
         WAIT_DONE: begin
            if (tx_done) begin
               state_nxt = GAP;
            end
         end
         GAP: begin
`ifdef UART_ARB_LOCK_EN
            if (req_valid[grant_id] && (tx_byte != 8'h0A) && !lock_brk) begin
               byte_nxt  = byte_sel(req_data, grant_id);
               state_nxt = ISSUE;
            end else begin
               state_nxt = IDLE;
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         grant_id <= ID_LAST;
         tx_byte  <= 8'h00;
         act_cnt  <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         tx_byte  <= byte_nxt;
         act_cnt  <= cnt_nxt;
         err      <= err_nxt;
      end
   end

`ifdef UART_ARB_LOCK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lock_brk <= 1'b0;
      end else begin
         lock_brk <= lock_brk_nxt;
      end
   end
`endif

   assign tx_dv = (state == ISSUE);
   assign busy  = (state != IDLE);

   always_comb begin
      req_ready = '0;
      if (state == ISSUE) begin
         req_ready[grant_id] = 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART TX core stub.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int AT  = 4;
   localparam int CPB = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           tx_dv;
   logic [7:0]     tx_byte;
   logic           tx_active = 1'b0;
   logic           tx_done = 1'b0;
   logic [1:0]     grant_id;
   logic           busy;
   logic           err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(N), .ACT_TIMEOUT(AT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_dv     (tx_dv),
      .tx_byte   (tx_byte),
      .tx_active (tx_active),
      .tx_done   (tx_done),
      .grant_id  (grant_id),
      .busy      (busy),
      .err       (err)
   );

   typedef struct {
      int         id;
      logic [7:0] b;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] rq[N][$];
   logic [7:0] hold_byte = 8'h00;
   logic [7:0] pop_dummy;
   int         errors = 0;
   int         checks = 0;
   int         dv_cnt = 0;
   bit         dead = 1'b0;
   bit         dv_seen = 1'b0;
   logic [7:0] byte_seen = 8'h00;

   typedef enum {C_IDLE, C_DATA, C_CLEAN} cst_t;
   cst_t cst = C_IDLE;
   int   clk_n = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]     = (rq[i].size() != 0);
         req_data[8*i +: 8] = (rq[i].size() != 0) ? rq[i][0] : 8'h00;
      end
   endtask

   task automatic sb_push(input int id, input logic [7:0] b);
      sb.push_back('{id: id, b: b});
   endtask

   function automatic bit pending();
      bit p = (sb.size() != 0);
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic check_reset_outs();
      chk("rst_tx_dv",     32'(tx_dv),     0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_tx_byte",   32'(tx_byte),   0);
      chk("rst_grant_id",  32'(grant_id),  N-1);
      chk("rst_busy",      32'(busy),      0);
      chk("rst_err",       32'(err),       0);
   endtask

   task automatic do_reset();
      rst  = 1'b0;
      dead = 1'b0;
      for (int i = 0; i < N; i++) rq[i].delete();
      sb.delete();
      drive_reqs();
      repeat (2) @(negedge clk);
      check_reset_outs();
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((pending() || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk("wait_idle_timeout", 0, 1);
      chk("sb_drained", sb.size(), 0);
   endtask

   // TX core stub: active one cycle after dv, 10-bit frame, done pulse, one cleanup cycle.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tx_done = 1'b0;
         if (!rst) begin
            cst       = C_IDLE;
            tx_active = 1'b0;
         end else begin
            case (cst)
               C_IDLE: if (dv_seen && !dead) begin
                  clk_n     = 0;
                  tx_active = 1'b1;
                  cst       = C_DATA;
               end
               C_DATA: begin
                  clk_n++;
                  if (clk_n == CPB * 10) begin
                     tx_active = 1'b0;
                     tx_done   = 1'b1;
                     cst       = C_CLEAN;
                  end
               end
               default: cst = C_IDLE;
            endcase
         end
      end
   end

   // Monitor: pop the scoreboard on each issued byte and play the requester side.
   initial begin
      forever begin
         @(negedge clk);
         dv_seen   = tx_dv;
         byte_seen = tx_byte;
         if (rst) begin
            if (tx_dv) begin
               dv_cnt++;
               if (cst == C_CLEAN) chk("dv_in_cleanup", 1, 0);
               if (sb.size() == 0) begin
                  chk("unexpected_dv", 32'(req_ready), 0);
               end else begin
                  mon_e = sb.pop_front();
                  chk("ready_onehot", 32'(req_ready), 1 << mon_e.id);
                  chk("issue_byte",   32'(tx_byte),   32'(mon_e.b));
                  chk("issue_grant",  32'(grant_id),  mon_e.id);
                  hold_byte = mon_e.b;
               end
               for (int i = 0; i < N; i++) begin
                  if (req_ready[i] && req_valid[i] && rq[i].size() != 0) pop_dummy = rq[i].pop_front();
               end
               drive_reqs();
            end else if (req_ready != '0) begin
               chk("stray_ready", 32'(req_ready), 0);
            end
            if (tx_active && tx_byte !== hold_byte) chk("byte_hold", 32'(tx_byte), 32'(hold_byte));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int d0;

      // Single byte from requester 0
      do_reset();
      rq[0].push_back(8'h55);
      sb_push(0, 8'h55);
      drive_reqs();
      d0 = dv_cnt;
      n = 0;
      while (!tx_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t1_done_seen", 32'(tx_done), 1);
      chk("t1_byte_in_frame", 32'(tx_byte), 32'h55);
      @(negedge clk);
      chk("t1_busy_gap", 32'(busy), 1);
      @(negedge clk);
      chk("t1_busy_idle", 32'(busy), 0);
      wait_idle(500);
      chk("t1_dv_count", dv_cnt - d0, 1);

      // All four requesters valid, two bytes each
      do_reset();
      for (int i = 0; i < N; i++) begin
         rq[i].push_back(8'hA0 + 8'(i));
         rq[i].push_back(8'hB0 + 8'(i));
      end
`ifdef UART_ARB_LOCK_EN
      for (int i = 0; i < N; i++) begin
         sb_push(i, 8'hA0 + 8'(i));
         sb_push(i, 8'hB0 + 8'(i));
      end
`else
      for (int i = 0; i < N; i++) sb_push(i, 8'hA0 + 8'(i));
      for (int i = 0; i < N; i++) sb_push(i, 8'hB0 + 8'(i));
`endif
      drive_reqs();
      wait_idle(2000);

      // Core never goes active: timeout sets err, next requester still served
      do_reset();
      dead = 1'b1;
      rq[0].push_back(8'h11);
      rq[1].push_back(8'h22);
      sb_push(0, 8'h11);
      sb_push(1, 8'h22);
      drive_reqs();
      n = 0;
      while (!tx_dv && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t3_dv_seen", 32'(tx_dv), 1);
      repeat (AT) @(negedge clk);
      chk("t3_err_not_yet", 32'(err), 0);
      @(negedge clk);
      chk("t3_err_set", 32'(err), 1);
      chk("t3_busy_gap", 32'(busy), 1);
      @(negedge clk);
      chk("t3_back_idle", 32'(busy), 0);
      wait_idle(200);
      chk("t3_err_sticky", 32'(err), 1);

      // Reset in the middle of a frame
      do_reset();
      rq[2].push_back(8'h77);
      sb_push(2, 8'h77);
      drive_reqs();
      n = 0;
      while (!tx_active && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t4_active_seen", 32'(tx_active), 1);
      repeat (5) @(negedge clk);
      chk("t4_in_frame", 32'(busy), 1);
      rst = 1'b0;
      #1;
      check_reset_outs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      d0 = dv_cnt;
      repeat (20) @(negedge clk);
      chk("t4_no_dv_after_reset", dv_cnt - d0, 0);
      chk("t4_idle_after_reset", 32'(busy), 0);
      rq[1].push_back(8'h31);
      sb_push(1, 8'h31);
      drive_reqs();
      wait_idle(500);

      // Line "hi\n" from requester 1 competing with requester 2
      do_reset();
      rq[1].push_back(8'h68);
      rq[1].push_back(8'h69);
      rq[1].push_back(8'h0A);
      rq[2].push_back(8'hB0);
      rq[2].push_back(8'hB1);
      rq[2].push_back(8'hB2);
`ifdef UART_ARB_LOCK_EN
      sb_push(1, 8'h68);
      sb_push(1, 8'h69);
      sb_push(1, 8'h0A);
      sb_push(2, 8'hB0);
      sb_push(2, 8'hB1);
      sb_push(2, 8'hB2);
`else
      sb_push(1, 8'h68);
      sb_push(2, 8'hB0);
      sb_push(1, 8'h69);
      sb_push(2, 8'hB1);
      sb_push(1, 8'h0A);
      sb_push(2, 8'hB2);
`endif
      drive_reqs();
      wait_idle(3000);

      // Requester 0 raises then drops valid while requester 1 transmits
      do_reset();
      rq[1].push_back(8'hC1);
      rq[1].push_back(8'hC2);
      sb_push(1, 8'hC1);
      sb_push(1, 8'hC2);
      drive_reqs();
      n = 0;
      while (!tx_active && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_active_seen", 32'(tx_active), 1);
      rq[0].push_back(8'hC0);
      drive_reqs();
      repeat (8) @(negedge clk);
      rq[0].delete();
      drive_reqs();
      wait_idle(1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
